// File: rtl/adc_trig_capture_buffer_if.sv
// adc_trig_capture_buffer_if
//   Bundles the sample stream, trigger controls and the display read port of
//   adc_trig_capture_buffer.
//   slave  : capture buffer side (inputs: sample/control/read address,
//            outputs: read data and status)
//   master : ADC driver / controller / renderer side (the reverse directions)
// Signals:
//   SAMPLE_EN, SAMPLE_DATA     sample strobe and ADC data
//   TRIGGER_LEVEL, TRIG_SLOPE  threshold and edge select (0 rising, 1 falling)
//   SINGLE_SHOT, ARM           capture mode and start pulse
//   READ_DONE, RD_ADDR         reader release pulse and logical read index
//   RD_DATA, TRIG_ADDR         registered read data, physical trigger address
//   CAPTURE_VALID, STATE       record frozen flag, state encoding
//   TRIG_AUTO                  last trigger was forced by timeout
interface adc_trig_capture_buffer_if #(
    parameter int DW = 8,
    parameter int AW = 11
);
    logic          SAMPLE_EN;
    logic [DW-1:0] SAMPLE_DATA;
    logic [DW-1:0] TRIGGER_LEVEL;
    logic          TRIG_SLOPE;
    logic          SINGLE_SHOT;
    logic          ARM;
    logic          READ_DONE;
    logic [AW-1:0] RD_ADDR;
    logic [DW-1:0] RD_DATA;
    logic [AW-1:0] TRIG_ADDR;
    logic          CAPTURE_VALID;
    logic [2:0]    STATE;
    logic          TRIG_AUTO;

    modport slave (
        input  SAMPLE_EN, SAMPLE_DATA, TRIGGER_LEVEL, TRIG_SLOPE, SINGLE_SHOT, ARM,
        input  READ_DONE, RD_ADDR,
        output RD_DATA, TRIG_ADDR, CAPTURE_VALID, STATE, TRIG_AUTO
    );

    modport master (
        output SAMPLE_EN, SAMPLE_DATA, TRIGGER_LEVEL, TRIG_SLOPE, SINGLE_SHOT, ARM,
        output READ_DONE, RD_ADDR,
        input  RD_DATA, TRIG_ADDR, CAPTURE_VALID, STATE, TRIG_AUTO
    );
endinterface

// File: rtl/adc_trig_capture_buffer.sv
// adc_trig_capture_buffer
//   Writes strobed ADC samples into a circular RAM, arms after PRE_TRIG
//   samples, detects a rising/falling threshold crossing, freezes a DEPTH-sample
//   record around the trigger and serves it in trigger-relative order.
// Ports:
//   CLK_64MHZ     system clock (rising edge)
//   MASTER_RST_N  asynchronous active-low reset
//   bus           adc_trig_capture_buffer_if.slave (samples, controls, read port)
// Optional feature macro: CAPTURE_AUTO_TRIG_EN -- forces a trigger after
//   AUTO_TIMEOUT ARMED samples and reports it on TRIG_AUTO.
module adc_trig_capture_buffer #(
    parameter int DW           = 8,
    parameter int AW           = 11,
    parameter int PRE_TRIG     = 1024,
    parameter int AUTO_TIMEOUT = 65535
) (
    input logic                       CLK_64MHZ,
    input logic                       MASTER_RST_N,
    adc_trig_capture_buffer_if.slave  bus
);
    localparam int DEPTH    = 2 ** AW;
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPrefill = 3'd1,
        StArmed   = 3'd2,
        StPost    = 3'd3,
        StDone    = 3'd4
    } state_e;

    state_e        r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_pre_cnt;
    logic [AW-1:0] r_post_cnt;
    logic [AW-1:0] r_trig_addr;
    logic [DW-1:0] r_prev;
    logic          r_prev_valid;
    logic          r_capture_valid;
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_wr_en;
    logic          w_rise;
    logic          w_fall;
    logic          w_trig_hit;
    logic          w_auto_hit;
    logic [AW-1:0] w_pre_nxt;
    logic [AW-1:0] w_post_nxt;
    logic [AW-1:0] w_rd_phys;

    assign w_wr_en    = bus.SAMPLE_EN &&
                        (r_state == StPrefill || r_state == StArmed || r_state == StPost);
    assign w_pre_nxt  = r_pre_cnt + AW'(1);
    assign w_post_nxt = r_post_cnt + AW'(1);

    // Crossing is judged between the previous strobed sample and the current one.
    assign w_rise     = r_prev_valid && (r_prev < bus.TRIGGER_LEVEL) &&
                        (bus.SAMPLE_DATA >= bus.TRIGGER_LEVEL);
    assign w_fall     = r_prev_valid && (r_prev >= bus.TRIGGER_LEVEL) &&
                        (bus.SAMPLE_DATA < bus.TRIGGER_LEVEL);
    assign w_trig_hit = bus.TRIG_SLOPE ? w_fall : w_rise;

    // Logical index 0 is the oldest pre-trigger sample.
    assign w_rd_phys  = r_trig_addr - AW'(PRE_TRIG) + bus.RD_ADDR;

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_trig_auto;
    assign w_auto_hit    = (r_to_cnt + TW'(1)) == TW'(AUTO_TIMEOUT);
    assign bus.TRIG_AUTO = r_trig_auto;
`else
    logic w_unused_auto;
    assign w_unused_auto = ^AUTO_TIMEOUT;
    assign w_auto_hit    = 1'b0;
    assign bus.TRIG_AUTO = 1'b0;
`endif

    always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
        if (!MASTER_RST_N) begin
            r_state         <= StIdle;
            r_wr_ptr        <= '0;
            r_pre_cnt       <= '0;
            r_post_cnt      <= '0;
            r_trig_addr     <= '0;
            r_prev          <= '0;
            r_prev_valid    <= 1'b0;
            r_capture_valid <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
            r_to_cnt        <= '0;
            r_trig_auto     <= 1'b0;
`endif
        end else begin
            // Any writing state advances the pointer and tracks prev.
            if (w_wr_en) begin
                r_wr_ptr     <= r_wr_ptr + AW'(1);
                r_prev       <= bus.SAMPLE_DATA;
                r_prev_valid <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (bus.ARM) begin
                        r_state      <= StPrefill;
                        r_pre_cnt    <= '0;
                        r_prev_valid <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
                        r_trig_auto  <= 1'b0;
`endif
                    end
                end
                StPrefill: begin
                    if (bus.SAMPLE_EN) begin
                        r_pre_cnt <= w_pre_nxt;
                        if (w_pre_nxt == AW'(PRE_TRIG)) begin
                            r_state <= StArmed;
`ifdef CAPTURE_AUTO_TRIG_EN
                            r_to_cnt <= '0;
`endif
                        end
                    end
                end
                StArmed: begin
                    if (bus.SAMPLE_EN) begin
`ifdef CAPTURE_AUTO_TRIG_EN
                        r_to_cnt <= r_to_cnt + TW'(1);
`endif
                        if (w_trig_hit || w_auto_hit) begin
                            r_state     <= StPost;
                            r_trig_addr <= r_wr_ptr;
                            r_post_cnt  <= '0;
`ifdef CAPTURE_AUTO_TRIG_EN
                            // A genuine crossing on the timeout sample wins.
                            r_trig_auto <= ~w_trig_hit;
`endif
                        end
                    end
                end
                StPost: begin
                    if (bus.SAMPLE_EN) begin
                        r_post_cnt <= w_post_nxt;
                        if (w_post_nxt == AW'(POST_LEN)) begin
                            r_state         <= StDone;
                            r_capture_valid <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (bus.READ_DONE) begin
                        r_capture_valid <= 1'b0;
                        if (bus.SINGLE_SHOT) begin
                            r_state <= StIdle;
                        end else begin
                            r_state      <= StPrefill;
                            r_pre_cnt    <= '0;
                            r_prev_valid <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
                            r_trig_auto  <= 1'b0;
`endif
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Sample RAM: contents are not reset.
    always_ff @(posedge CLK_64MHZ) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= bus.SAMPLE_DATA;
        end
    end

    always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
        if (!MASTER_RST_N) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_rd_phys];
        end
    end

    assign bus.RD_DATA       = r_rd_data;
    assign bus.TRIG_ADDR     = r_trig_addr;
    assign bus.CAPTURE_VALID = r_capture_valid;
    assign bus.STATE         = r_state;
endmodule

// File: tb/tb_adc_trig_capture_buffer.sv
module tb_adc_trig_capture_buffer;
    logic clk;
    logic rst_n;
    logic rd_req;
    int   checks;
    int   errors;

    logic [7:0] exp_rd_q[$];
    int         exp_ad_q[$];
    logic [4:0] exp_cap_q[$];   // {trig_auto, trig_addr}

    adc_trig_capture_buffer_if #(.DW(8), .AW(4)) bus ();

    adc_trig_capture_buffer #(
        .DW          (8),
        .AW          (4),
        .PRE_TRIG    (4),
        .AUTO_TIMEOUT(20)
    ) dut (
        .CLK_64MHZ   (clk),
        .MASTER_RST_N(rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read responses one cycle after a request, capture records on
    // each CAPTURE_VALID rise.
    initial begin
        logic       req;
        logic       cv_q;
        logic [7:0] e;
        logic [4:0] c;
        int         a;
        cv_q = 1'b0;
        forever begin
            @(posedge clk);
            req = rd_req;
            @(negedge clk);
            if (req) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got 0x%0h, expected no response", bus.RD_DATA);
                end else begin
                    e = exp_rd_q.pop_front();
                    a = exp_ad_q.pop_front();
                    if (bus.RD_DATA !== e) begin
                        errors++;
                        $display("FAIL rd_data[%0d]: got 0x%0h, expected 0x%0h", a, bus.RD_DATA, e);
                    end
                end
            end
            if (bus.CAPTURE_VALID && !cv_q) begin
                checks++;
                if (exp_cap_q.size() == 0) begin
                    errors++;
                    $display("FAIL cap_unexpected: got trig_addr %0d, expected no capture",
                             bus.TRIG_ADDR);
                end else begin
                    c = exp_cap_q.pop_front();
                    if ({bus.TRIG_AUTO, bus.TRIG_ADDR} !== c) begin
                        errors++;
                        $display("FAIL cap_record: got auto %0d addr %0d, expected auto %0d addr %0d",
                                 bus.TRIG_AUTO, bus.TRIG_ADDR, c[4], c[3:0]);
                    end
                end
            end
            cv_q = bus.CAPTURE_VALID;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bus.SAMPLE_EN   = 1'b1;
        bus.SAMPLE_DATA = d;
        tick();
        bus.SAMPLE_EN = 1'b0;
        tick();
    endtask

    task automatic arm();
        bus.ARM = 1'b1;
        tick();
        bus.ARM = 1'b0;
    endtask

    task automatic read_done();
        bus.READ_DONE = 1'b1;
        tick();
        bus.READ_DONE = 1'b0;
    endtask

    task automatic rd(input int a, input logic [7:0] e);
        bus.RD_ADDR = 4'(a);
        rd_req      = 1'b1;
        exp_rd_q.push_back(e);
        exp_ad_q.push_back(a);
        tick();
    endtask

    task automatic rd_flush();
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        rd_req = 1'b0;
        bus.SAMPLE_EN     = 1'b0;
        bus.SAMPLE_DATA   = 8'h00;
        bus.TRIGGER_LEVEL = 8'h80;
        bus.TRIG_SLOPE    = 1'b0;
        bus.SINGLE_SHOT   = 1'b1;
        bus.ARM           = 1'b0;
        bus.READ_DONE     = 1'b0;
        bus.RD_ADDR       = 4'd0;
        repeat (3) tick();
        chk("rst_state", bus.STATE, 0);
        chk("rst_valid", bus.CAPTURE_VALID, 0);
        chk("rst_trig_addr", bus.TRIG_ADDR, 0);
        chk("rst_rd_data", bus.RD_DATA, 0);
        chk("rst_trig_auto", bus.TRIG_AUTO, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of POST aborts the capture.
        arm();
        chk("arm_to_prefill", bus.STATE, 1);
        repeat (4) send(8'h00);
        chk("prefill_to_armed", bus.STATE, 2);
        send(8'h90);
        chk("mid_trig_post", bus.STATE, 3);
        chk("mid_trig_addr", bus.TRIG_ADDR, 4);
        bus.RD_ADDR = 4'd4;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("mid_rd_data", bus.RD_DATA, 8'h90);
        rst_n = 1'b0;
        #1;
        chk("abort_state", bus.STATE, 0);
        chk("abort_valid", bus.CAPTURE_VALID, 0);
        chk("abort_trig_addr", bus.TRIG_ADDR, 0);
        chk("abort_rd_data", bus.RD_DATA, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Rising ramp from wr_ptr 0; the sample on the ARM edge is dropped.
        bus.ARM         = 1'b1;
        bus.SAMPLE_EN   = 1'b1;
        bus.SAMPLE_DATA = 8'hEE;
        tick();
        bus.ARM       = 1'b0;
        bus.SAMPLE_EN = 1'b0;
        tick();
        chk("rise_prefill", bus.STATE, 1);
        for (int i = 0; i < 8; i++) send(8'(16 * i));
        chk("rise_armed", bus.STATE, 2);
        exp_cap_q.push_back({1'b0, 4'd8});
        send(8'h80);
        chk("rise_post", bus.STATE, 3);
        chk("rise_trig_addr", bus.TRIG_ADDR, 8);
        for (int i = 1; i <= 10; i++) send(8'(8'h80 + 16 * i));
        chk("rise_not_done", bus.CAPTURE_VALID, 0);
        send(8'h30);
        chk("rise_valid", bus.CAPTURE_VALID, 1);
        chk("rise_done", bus.STATE, 4);
        for (int i = 0; i < 16; i++) rd(i, 8'(8'h40 + 16 * i));
        rd_flush();
        // DONE holds the record: no writes, ARM ignored.
        send(8'hEE);
        arm();
        chk("done_arm_ignored", bus.STATE, 4);
        rd(0, 8'h40);
        rd(15, 8'h30);
        rd_flush();
        read_done();
        chk("single_idle", bus.STATE, 0);
        chk("single_valid_clr", bus.CAPTURE_VALID, 0);

        // Falling ramp.
        bus.TRIG_SLOPE = 1'b1;
        arm();
        exp_cap_q.push_back({1'b0, 4'd12});
        for (int i = 0; i < 9; i++) send(8'(8'hF0 - 16 * i));
        chk("fall_post", bus.STATE, 3);
        chk("fall_trig_addr", bus.TRIG_ADDR, 12);
        for (int i = 1; i <= 11; i++) send(8'(8'h70 - 16 * i));
        chk("fall_valid", bus.CAPTURE_VALID, 1);
        rd(0, 8'hB0);
        rd(1, 8'hA0);
        rd(4, 8'h70);
        rd(15, 8'hC0);
        rd_flush();
        bus.SINGLE_SHOT = 1'b0;
        read_done();
        chk("rearm_prefill", bus.STATE, 1);
        chk("rearm_valid_clr", bus.CAPTURE_VALID, 0);

        // Rising ramp with falling slope never triggers; then a real fall does.
        for (int i = 0; i < 16; i++) send(8'(16 * i));
        chk("wrong_slope_armed", bus.STATE, 2);
        chk("wrong_slope_valid", bus.CAPTURE_VALID, 0);
        exp_cap_q.push_back({1'b0, 4'd8});
        send(8'h70);
        chk("rearm_trig_addr", bus.TRIG_ADDR, 8);
        for (int i = 1; i <= 11; i++) send(8'(8'hA0 + i));
        chk("rearm_valid", bus.CAPTURE_VALID, 1);
        chk("rearm_done", bus.STATE, 4);
        for (int i = 0; i < 16; i++)
            rd(i, (i < 4) ? 8'(8'hC0 + 16 * i) : (i == 4) ? 8'h70 : 8'(8'hA0 + i - 4));
        rd_flush();

        // READ_DONE with a coincident sample: that sample is not written.
        bus.TRIG_SLOPE  = 1'b0;
        bus.READ_DONE   = 1'b1;
        bus.SAMPLE_EN   = 1'b1;
        bus.SAMPLE_DATA = 8'h5A;
        tick();
        bus.READ_DONE = 1'b0;
        bus.SAMPLE_EN = 1'b0;
        tick();
        chk("rd_done_sample_prefill", bus.STATE, 1);
        for (int i = 1; i <= 14; i++) send(8'(i));
        exp_cap_q.push_back({1'b0, 4'd2});
        send(8'h90);
        chk("wrap1_trig_addr", bus.TRIG_ADDR, 2);
        for (int i = 1; i <= 11; i++) send(8'(8'h90 + i));
        chk("wrap1_valid", bus.CAPTURE_VALID, 1);
        for (int i = 0; i < 16; i++)
            rd(i, (i < 4) ? 8'(8'h0B + i) : 8'(8'h90 + i - 4));
        rd_flush();
        bus.SINGLE_SHOT = 1'b1;
        read_done();
        chk("wrap1_idle", bus.STATE, 0);

        // ARM with wr_ptr at 14: record crosses the 15 -> 0 boundary.
        arm();
        for (int i = 1; i <= 4; i++) send(8'(8'h20 + i));
        exp_cap_q.push_back({1'b0, 4'd2});
        send(8'hC0);
        chk("wrap2_trig_addr", bus.TRIG_ADDR, 2);
        for (int i = 1; i <= 11; i++) send(8'(8'hC0 + i));
        chk("wrap2_valid", bus.CAPTURE_VALID, 1);
        for (int i = 0; i < 16; i++)
            rd(i, (i < 4) ? 8'(8'h21 + i) : 8'(8'hC0 + i - 4));
        rd_flush();
        read_done();
        chk("wrap2_idle", bus.STATE, 0);

        // Constant input: only the timeout can trigger.
        arm();
        repeat (4) send(8'h10);
        chk("const_armed", bus.STATE, 2);
`ifdef CAPTURE_AUTO_TRIG_EN
        repeat (19) send(8'h10);
        chk("auto_not_yet", bus.STATE, 2);
        exp_cap_q.push_back({1'b1, 4'd5});
        send(8'h10);
        chk("auto_post", bus.STATE, 3);
        chk("auto_flag", bus.TRIG_AUTO, 1);
        chk("auto_trig_addr", bus.TRIG_ADDR, 5);
        repeat (11) send(8'h10);
        chk("auto_valid", bus.CAPTURE_VALID, 1);
        bus.SINGLE_SHOT = 1'b0;
        read_done();
        chk("auto_rearm", bus.STATE, 1);
        chk("auto_flag_clr", bus.TRIG_AUTO, 0);
`else
        repeat (25) send(8'h10);
        chk("noauto_armed", bus.STATE, 2);
        chk("noauto_flag", bus.TRIG_AUTO, 0);
        chk("noauto_valid", bus.CAPTURE_VALID, 0);
`endif

        repeat (3) tick();
        chk("rd_queue_drained", exp_rd_q.size(), 0);
        chk("cap_queue_drained", exp_cap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
